multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences a multicycle version of the team's 32-bit MIPS-subset datapath: PC, instruction register, register file, sign-extend, 2-bit-control ALU and a single shared instruction/data memory.
- Decodes Inst[31:26] and issues per-cycle mux selects and write strobes.
- Supports variable-latency memory through a MemReady handshake, with a timeout watchdog.
- Sits beside the datapath top level and replaces the single-cycle ControlUnit.

Parameters:
- WAIT_LIMIT, 15: maximum cycles one memory access may wait for MemReady before a timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Op  in  6  opcode, Inst[31:26] from the instruction register.
- zeroFlag  in  1  ALU zero flag.
- MemReady  in  1  memory access complete this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when zeroFlag=1.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  write-back data select: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination select: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=RD1.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=4, 10=signext, 11=signext<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct decode, 11=reserved (never driven).
- PCSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- IllegalOp  out  1  one-cycle pulse when an unsupported opcode reaches DECODE.
- MemTimeout  out  1  sticky flag; cleared only by reset.
- InstCount  out  CNT_W  retired-instruction counter.
- State  out  4  current state encoding, for debug.

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Reset:
  - While RST_n=0, State=FETCH(0), InstCount=0, MemTimeout=0, wait counter=0.
  - All strobe and select outputs are forced to 0.
  - The first FETCH begins on the first rising edge after RST_n deasserts.
  - Asserting reset mid-instruction abandons it with no further writes.
- States and transitions (4-bit encoding):
  - FETCH=0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite assert only in a cycle where MemReady=1; then go to DECODE. Otherwise stay.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
    - lw/sw go to MEMADR; R-type to EXEC; beq to BRANCH; j to JUMP; addi to ADDIEX.
    - Any other opcode: IllegalOp=1 for this cycle, go to FETCH, InstCount unchanged.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD=3: MemRead, IorD=1. Stay until MemReady, then go to MEMWB.
  - MEMWB=4: RegWrite, RegDst=0, MemToReg=1. Go to FETCH and retire.
  - MEMWR=5: MemWrite, IorD=1. Stay until MemReady, then go to FETCH and retire.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
  - RWB=7: RegWrite, RegDst=1, MemToReg=0. Go to FETCH and retire.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Go to FETCH and retire; the PC is taken only if zeroFlag=1.
  - JUMP=9: PCWrite, PCSource=10. Go to FETCH and retire.
  - ADDIEX=10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB=11: RegWrite, RegDst=0, MemToReg=0. Go to FETCH and retire.
  - HALT=12: all strobes 0. Exits only on reset.
  - Encodings 13–15: go to FETCH next cycle with all strobes 0.
- Retire: InstCount increments by 1 on the clock edge leaving the final state. It wraps modulo 2^CNT_W.
- Wait states (FETCH, MEMRD, MEMWR):
  - The wait counter clears on entry and increments each cycle MemReady=0.
  - If it reaches WAIT_LIMIT with MemReady still 0: MemTimeout sets, go to HALT.
  - MemReady=1 on the limit cycle itself completes the access normally; success takes priority over timeout.
- Strobes are decoded from State only, except IRWrite and PCWrite in FETCH, which are ANDed with MemReady. There is no output register latency.
- Same-cycle events: IllegalOp in DECODE never coincides with RegWrite or MemWrite.

Decomposition:
- Package mcu_pkg holds:
  - opcode localparams;
  - state encodings;
  - ALUOp, ALUSrcB and PCSource codes.
- One sub-module, mem_wait_timer: wait counter plus timeout compare, with start/ready inputs and an expire output.
- The FSM next-state and output-decode logic stay in the top level.

Test Plan:
- lw with MemReady tied 1 → states 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; InstCount 0→1.
- R-type then addi, MemReady=1 → R-type takes 4 cycles, addi 4 cycles; RegDst=1 for R-type, 0 for addi; InstCount=2.
- beq with zeroFlag=1, then zeroFlag=0 → PCWriteCond=1 and PCSource=01 in state 8 both times; each takes 3 cycles; InstCount +2.
- FETCH with MemReady low 3 cycles then high → IRWrite and PCWrite assert only on the 4th cycle; no timeout.
- MemReady held 0 in MEMWR, WAIT_LIMIT=15 → MemTimeout=1 and State=12 after 15 wait cycles; remains halted until RST_n pulse, after which State=0 and MemTimeout=0.
- Op=111111 → IllegalOp pulse in DECODE, return to FETCH, InstCount unchanged. Separately, RST_n asserted in state 3 → all strobes 0 immediately (asynchronous), State=0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// mcu_pkg: shared constants for the multicycle control unit.
//   - opcode values, Inst[31:26]
//   - 4-bit FSM state encodings
//   - ALUOp, ALUSrcB and PCSource select codes
//   - ctrl_t bundles every strobe and select driven toward the datapath
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    // States that own a memory access and may stall on MemReady.
    function automatic logic isWaitState(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control unit <-> datapath bundle.
//   datapath -> control : Op, zeroFlag, MemReady
//   control -> datapath : PC/IR/memory/regfile strobes, mux selects,
//                         IllegalOp, MemTimeout, InstCount, State
//   master modport = control unit, slave modport = datapath side.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic             zeroFlag;
    logic             MemReady;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemToReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             IllegalOp;
    logic             MemTimeout;
    logic [CNT_W-1:0] InstCount;
    logic [3:0]       State;

    modport master (
        input  Op, zeroFlag, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, MemTimeout, InstCount, State
    );

    modport slave (
        output Op, zeroFlag, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, MemTimeout, InstCount, State
    );

endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// mem_wait_timer: counts stalled cycles of one memory access.
//   CLK, RST_n : clock, async active-low reset
//   start      : high every cycle a memory access is outstanding
//   ready      : MemReady from memory
//   expire     : this is the WAIT_LIMIT-th stalled cycle and memory is
//                still not ready; the access must be abandoned
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic start,
    input  logic ready,
    output logic expire
);

    localparam int W = $clog2(WAIT_LIMIT + 1);

    logic [W-1:0] waitCnt;

    // Fires combinationally in the stall that would take the count to the
    // limit; a ready in that same cycle wins, so success beats timeout.
    assign expire = start && !ready && (waitCnt == W'(WAIT_LIMIT - 1));

    // Completion or leaving the wait state clears the count, so every new
    // access starts from zero, including back-to-back MEMWR -> FETCH.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            waitCnt <= '0;
        else if (start && !ready)
            waitCnt <= waitCnt + W'(1);
        else
            waitCnt <= '0;
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing the multicycle MIPS-subset
// datapath (R-type, lw, sw, beq, j, addi).
//   CLK, RST_n : clock, async active-low reset
//   bus        : master side of multicycle_control_unit_if
//                (Op/zeroFlag/MemReady in; strobes, selects, IllegalOp,
//                 MemTimeout, InstCount, State out)
// Outputs decode from State only; IRWrite/PCWrite in FETCH also need
// MemReady. Everything is forced low while RST_n is asserted.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic                        CLK,
    input  logic                        RST_n,
    multicycle_control_unit_if.master   bus
);

    state_t           state, stateNext;
    ctrl_t            ctl;
    logic             retire;
    logic             illegal;
    logic             inWait;
    logic             expire;
    logic [CNT_W-1:0] instCount;
    logic             memTimeout;

    assign inWait = isWaitState(state);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) uTimer (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .start  (inWait),
        .ready  (bus.MemReady),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= S_FETCH;
            instCount  <= '0;
            memTimeout <= 1'b0;
        end else begin
            state <= stateNext;
            if (retire)
                instCount <= instCount + CNT_W'(1);
            if (expire)
                memTimeout <= 1'b1;
        end
    end

    always_comb begin
        ctl       = '0;
        stateNext = state;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                ctl.memRead  = 1'b1;
                ctl.aluSrcB  = SRCB_FOUR;
                ctl.aluOp    = ALU_ADD;
                ctl.pcSource = PCSRC_ALU;
                if (bus.MemReady) begin
                    ctl.irWrite = 1'b1;
                    ctl.pcWrite = 1'b1;
                    stateNext   = S_DECODE;
                end else if (expire) begin
                    stateNext = S_HALT;
                end
            end
            S_DECODE: begin
                // Branch target PC+(imm<<2) precomputed into ALUOut here.
                ctl.aluSrcB = SRCB_IMMSH;
                ctl.aluOp   = ALU_ADD;
                case (bus.Op)
                    OP_LW, OP_SW: stateNext = S_MEMADR;
                    OP_RTYPE:     stateNext = S_EXEC;
                    OP_BEQ:       stateNext = S_BRANCH;
                    OP_J:         stateNext = S_JUMP;
                    OP_ADDI:      stateNext = S_ADDIEX;
                    default: begin
                        illegal   = 1'b1;
                        stateNext = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_IMM;
                ctl.aluOp   = ALU_ADD;
                stateNext   = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl.memRead = 1'b1;
                ctl.iorD    = 1'b1;
                if (bus.MemReady)
                    stateNext = S_MEMWB;
                else if (expire)
                    stateNext = S_HALT;
            end
            S_MEMWB: begin
                ctl.regWrite = 1'b1;
                ctl.memToReg = 1'b1;
                stateNext    = S_FETCH;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                ctl.memWrite = 1'b1;
                ctl.iorD     = 1'b1;
                if (bus.MemReady) begin
                    stateNext = S_FETCH;
                    retire    = 1'b1;
                end else if (expire) begin
                    stateNext = S_HALT;
                end
            end
            S_EXEC: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_RD2;
                ctl.aluOp   = ALU_FUNCT;
                stateNext   = S_RWB;
            end
            S_RWB: begin
                ctl.regWrite = 1'b1;
                ctl.regDst   = 1'b1;
                stateNext    = S_FETCH;
                retire       = 1'b1;
            end
            S_BRANCH: begin
                // Datapath qualifies PCWriteCond with zeroFlag.
                ctl.aluSrcA     = 1'b1;
                ctl.aluSrcB     = SRCB_RD2;
                ctl.aluOp       = ALU_SUB;
                ctl.pcWriteCond = 1'b1;
                ctl.pcSource    = PCSRC_ALUOUT;
                stateNext       = S_FETCH;
                retire          = 1'b1;
            end
            S_JUMP: begin
                ctl.pcWrite  = 1'b1;
                ctl.pcSource = PCSRC_JUMP;
                stateNext    = S_FETCH;
                retire       = 1'b1;
            end
            S_ADDIEX: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_IMM;
                ctl.aluOp   = ALU_ADD;
                stateNext   = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.regWrite = 1'b1;
                stateNext    = S_FETCH;
                retire       = 1'b1;
            end
            S_HALT: stateNext = S_HALT;
            default: stateNext = S_FETCH;
        endcase
    end

    assign bus.PCWrite     = RST_n & ctl.pcWrite;
    assign bus.PCWriteCond = RST_n & ctl.pcWriteCond;
    assign bus.IorD        = RST_n & ctl.iorD;
    assign bus.MemRead     = RST_n & ctl.memRead;
    assign bus.MemWrite    = RST_n & ctl.memWrite;
    assign bus.IRWrite     = RST_n & ctl.irWrite;
    assign bus.MemToReg    = RST_n & ctl.memToReg;
    assign bus.RegDst      = RST_n & ctl.regDst;
    assign bus.RegWrite    = RST_n & ctl.regWrite;
    assign bus.ALUSrcA     = RST_n & ctl.aluSrcA;
    assign bus.ALUSrcB     = RST_n ? ctl.aluSrcB  : 2'b00;
    assign bus.ALUOp       = RST_n ? ctl.aluOp    : 2'b00;
    assign bus.PCSource    = RST_n ? ctl.pcSource : 2'b00;
    assign bus.IllegalOp   = RST_n & illegal;
    assign bus.MemTimeout  = memTimeout;
    assign bus.InstCount   = instCount;
    assign bus.State       = state;

endmodule
